// File: rtl/regfile_wb_scoreboard_pkg.sv
// Shared pipeline definitions for the writeback path and the register-file scoreboard.
package regfile_wb_scoreboard_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned NREGS      = 32;
    localparam int unsigned CNT_W      = 2;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;
    localparam logic [CNT_W-1:0]      CNT_MAX  = '1;

    // Writeback bundle as produced by the WB stage.
    typedef struct packed {
        logic                  reg_write;
        logic [REG_ADDR_W-1:0] write_reg;
        logic [DATA_W-1:0]     write_data;
    } wb_bundle_t;

endpackage

// File: rtl/regfile_wb_scoreboard_sb_counter.sv
// Saturating in-flight write counter: one increment and two independent decrements per cycle.
module sb_counter #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec_a,
    input  logic             dec_b,
    output logic [CNT_W-1:0] count,
    output logic             nonzero
);

    localparam int unsigned      EW    = CNT_W + 2;
    localparam logic [EW-1:0]    MAX_E = EW'((1 << CNT_W) - 1);

    logic [EW-1:0] up_c;
    logic [EW-1:0] down_c;
    logic [EW-1:0] next_c;

    // Clamp the net delta into [0, max] instead of wrapping.
    always_comb begin
        up_c   = EW'(count) + EW'(inc);
        down_c = EW'(dec_a) + EW'(dec_b);
        next_c = '0;
        if (up_c >= down_c) begin
            next_c = up_c - down_c;
        end
        if (next_c > MAX_E) begin
            next_c = MAX_E;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= CNT_W'(next_c);
        end
    end

    assign nonzero = |count;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (up_c >= down_c)
                else $error("sb_counter: decrement of an empty counter");
            assert ((up_c < down_c) || ((up_c - down_c) <= MAX_E))
                else $error("sb_counter: increment of a full counter");
        end
    end
`endif

endmodule

// File: rtl/regfile_wb_scoreboard.sv
// Architectural register file with same-cycle WB bypass and a per-register pending-write scoreboard.
module regfile_wb_scoreboard
    import regfile_wb_scoreboard_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_write_reg,
    input  logic [DATA_W-1:0]     wb_write_data,
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [REG_ADDR_W-1:0] rt_addr,
    input  logic                  rs_used,
    input  logic                  rt_used,
    output logic [DATA_W-1:0]     rs_data,
    output logic [DATA_W-1:0]     rt_data,
    input  logic                  id_issue,
    input  logic                  id_dest_valid,
    input  logic [REG_ADDR_W-1:0] id_dest_reg,
    input  logic                  kill_valid,
    input  logic [REG_ADDR_W-1:0] kill_reg,
    output logic                  stall,
    output logic                  issue_ready
);

    wb_bundle_t        wb;
    logic [DATA_W-1:0] regs [NREGS];
    logic [CNT_W-1:0]  cnt  [NREGS];
    logic [NREGS-1:0]  nz;
    logic              dest_full_c;

    assign wb = '{reg_write: wb_reg_write, write_reg: wb_write_reg, write_data: wb_write_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else if (wb.reg_write && (wb.write_reg != ZERO_REG)) begin
            regs[wb.write_reg] <= wb.write_data;
        end
    end

    assign cnt[0] = '0;
    assign nz[0]  = 1'b0;

    for (genvar r = 1; r < int'(NREGS); r++) begin : g_cnt
        sb_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .inc     (id_issue && id_dest_valid && (id_dest_reg == REG_ADDR_W'(r))),
            .dec_a   (wb.reg_write && (wb.write_reg == REG_ADDR_W'(r))),
            .dec_b   (kill_valid && (kill_reg == REG_ADDR_W'(r))),
            .count   (cnt[r]),
            .nonzero (nz[r])
        );
    end

    function automatic logic wb_hits(input logic [REG_ADDR_W-1:0] a);
        return wb.reg_write && (wb.write_reg == a);
    endfunction

    function automatic logic [DATA_W-1:0] read_port(input logic [REG_ADDR_W-1:0] a);
        if (a == ZERO_REG) begin
            return '0;
        end
        return wb_hits(a) ? wb.write_data : regs[a];
    endfunction

    // A lone pending write retired by this cycle's WB is covered by the bypass.
    function automatic logic busy(input logic [REG_ADDR_W-1:0] a);
        return (a != ZERO_REG) && nz[a] && ((cnt[a] != CNT_W'(1)) || !wb_hits(a));
    endfunction

    always_comb begin
        rs_data     = read_port(rs_addr);
        rt_data     = read_port(rt_addr);
        dest_full_c = id_dest_valid && (id_dest_reg != ZERO_REG) &&
                      (cnt[id_dest_reg] == CNT_MAX) && !wb_hits(id_dest_reg);
        issue_ready = 1'b1;
        stall       = 1'b0;
        if (!rst) begin
            issue_ready = !dest_full_c;
            stall       = (rs_used && busy(rs_addr)) || (rt_used && busy(rt_addr)) || dest_full_c;
        end
    end

endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
// Scoreboard bench: behavioural register/pending-count model feeds a queue that a negedge monitor drains.
module tb_regfile_wb_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_reg_write;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;
    logic [4:0]  rs_addr, rt_addr;
    logic        rs_used, rt_used;
    logic [31:0] rs_data, rt_data;
    logic        id_issue, id_dest_valid;
    logic [4:0]  id_dest_reg;
    logic        kill_valid;
    logic [4:0]  kill_reg;
    logic        stall, issue_ready;

    always #5 clk = ~clk;

    regfile_wb_scoreboard dut (
        .clk           (clk),
        .rst           (rst),
        .wb_reg_write  (wb_reg_write),
        .wb_write_reg  (wb_write_reg),
        .wb_write_data (wb_write_data),
        .rs_addr       (rs_addr),
        .rt_addr       (rt_addr),
        .rs_used       (rs_used),
        .rt_used       (rt_used),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .id_issue      (id_issue),
        .id_dest_valid (id_dest_valid),
        .id_dest_reg   (id_dest_reg),
        .kill_valid    (kill_valid),
        .kill_reg      (kill_reg),
        .stall         (stall),
        .issue_ready   (issue_ready)
    );

    typedef struct {
        logic [31:0] rs;
        logic [31:0] rt;
        logic        stall;
        logic        ready;
    } exp_t;

    exp_t        q[$];
    logic [31:0] regs_m [32];
    int          cnt_m  [32];
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit wb_on(input logic [4:0] a);
        return wb_reg_write && (wb_write_reg == a);
    endfunction

    function automatic logic [31:0] rd_m(input logic [4:0] a);
        if (a == 0) return 32'd0;
        if (wb_on(a)) return wb_write_data;
        return regs_m[a];
    endfunction

    function automatic bit busy_m(input logic [4:0] a);
        int pending;
        pending = cnt_m[a] - (wb_on(a) ? 1 : 0);
        return (a != 0) && (pending > 0);
    endfunction

    function automatic exp_t expect_now();
        exp_t e;
        bit   full;
        e.rs  = rd_m(rs_addr);
        e.rt  = rd_m(rt_addr);
        full  = id_dest_valid && (id_dest_reg != 0) && (cnt_m[id_dest_reg] == 3) && !wb_on(id_dest_reg);
        e.ready = rst ? 1'b1 : !full;
        e.stall = rst ? 1'b0 : ((rs_used && busy_m(rs_addr)) || (rt_used && busy_m(rt_addr)) || full);
        return e;
    endfunction

    task automatic commit();
        int d;
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                regs_m[r] = 32'd0;
                cnt_m[r]  = 0;
            end
        end else begin
            if (wb_reg_write && wb_write_reg != 0) regs_m[wb_write_reg] = wb_write_data;
            for (int r = 1; r < 32; r++) begin
                d = 0;
                if (id_issue && id_dest_valid && id_dest_reg == 5'(r)) d++;
                if (wb_reg_write && wb_write_reg == 5'(r)) d--;
                if (kill_valid && kill_reg == 5'(r)) d--;
                cnt_m[r] = cnt_m[r] + d;
                if (cnt_m[r] < 0) cnt_m[r] = 0;
                if (cnt_m[r] > 3) cnt_m[r] = 3;
            end
        end
    endtask

    task automatic idle();
        rst = 0; wb_reg_write = 0; wb_write_reg = 0; wb_write_data = 0;
        rs_addr = 0; rt_addr = 0; rs_used = 0; rt_used = 0;
        id_issue = 0; id_dest_valid = 0; id_dest_reg = 0;
        kill_valid = 0; kill_reg = 0;
    endtask

    task automatic tick(input bit chk = 1'b1);
        if (chk) q.push_back(expect_now());
        @(posedge clk);
        commit();
        #1;
    endtask

    task automatic issue(input logic [4:0] r);
        idle(); id_issue = 1; id_dest_valid = 1; id_dest_reg = r; tick();
    endtask

    task automatic wb(input logic [4:0] r, input logic [31:0] d);
        idle(); wb_reg_write = 1; wb_write_reg = r; wb_write_data = d; tick();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("rs_data", rs_data, e.rs);
            check("rt_data", rt_data, e.rt);
            check("stall", 32'(stall), 32'(e.stall));
            check("issue_ready", 32'(issue_ready), 32'(e.ready));
        end
    end

    initial begin
        int   avail [32];
        int   r;
        exp_t e;
        idle();
        @(posedge clk); #1;
        rst = 1; tick(1'b0);
        // reset and r0
        rst = 1; tick(); tick();
        idle();
        for (int a = 0; a < 32; a++) begin
            rs_addr = 5'(a); rt_addr = 5'(31 - a); rs_used = 1; rt_used = 1; tick();
        end
        idle(); wb_reg_write = 1; wb_write_reg = 0; wb_write_data = 32'hDEADBEEF; rs_addr = 0; rs_used = 1; tick();
        idle(); rs_addr = 0; rs_used = 1; tick();
        // write with same-cycle bypass
        issue(5);
        idle(); wb_reg_write = 1; wb_write_reg = 5; wb_write_data = 32'h12345678; rs_addr = 5; rs_used = 1; tick();
        idle(); rs_addr = 5; rs_used = 1; tick();
        // load-use stall
        issue(7);
        for (int i = 0; i < 3; i++) begin
            idle(); rs_addr = 7; rs_used = 1; tick();
        end
        idle(); wb_reg_write = 1; wb_write_reg = 7; wb_write_data = 32'hA5A5A5A5; rs_addr = 7; rs_used = 1; tick();
        idle(); rs_addr = 7; rs_used = 1; tick();
        // counter saturation
        issue(3); issue(3); issue(3);
        idle(); id_dest_valid = 1; id_dest_reg = 3; tick();
        idle(); id_dest_valid = 1; id_dest_reg = 3; wb_reg_write = 1; wb_write_reg = 3; wb_write_data = 32'h33; tick();
        idle(); id_dest_valid = 1; id_dest_reg = 3; tick();
        wb(3, 32'h34); wb(3, 32'h35);
        // simultaneous issue and writeback
        issue(9);
        idle(); id_issue = 1; id_dest_valid = 1; id_dest_reg = 9;
        wb_reg_write = 1; wb_write_reg = 9; wb_write_data = 32'h99; tick();
        idle(); rt_addr = 9; rt_used = 1; tick();
        wb(9, 32'h9A);
        idle(); rt_addr = 9; rt_used = 1; tick();
        // kill, then reset with a write pending
        issue(4); issue(4);
        idle(); kill_valid = 1; kill_reg = 4; tick();
        idle(); rs_addr = 4; rs_used = 1; tick();
        idle(); rst = 1; wb_reg_write = 1; wb_write_reg = 4; wb_write_data = 32'h55; tick();
        idle(); rs_addr = 4; rs_used = 1; id_dest_valid = 1; id_dest_reg = 4; tick();
        // randomized traffic confined to a small register window
        for (int n = 0; n < 1500; n++) begin
            idle();
            for (int k = 0; k < 32; k++) avail[k] = cnt_m[k];
            rs_addr = 5'($urandom_range(0, 7));
            rt_addr = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) rs_addr = 5'($urandom_range(0, 31));
            rs_used = 1'($urandom_range(0, 1));
            rt_used = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) != 0) begin
                r = int'($urandom_range(0, 7));
                if (r == 0 || avail[r] > 0) begin
                    wb_reg_write = 1; wb_write_reg = 5'(r); wb_write_data = $urandom;
                    if (r != 0) avail[r]--;
                end
            end
            if ($urandom_range(0, 4) == 0) begin
                r = int'($urandom_range(1, 7));
                if (avail[r] > 0) begin
                    kill_valid = 1; kill_reg = 5'(r);
                end
            end
            id_dest_valid = ($urandom_range(0, 3) != 0);
            id_dest_reg   = 5'($urandom_range(0, 7));
            rst = ($urandom_range(0, 199) == 0);
            e = expect_now();
            id_issue = 1'($urandom_range(0, 1)) && !e.stall;
            tick();
        end
        idle();
        @(negedge clk); #1;
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_wb_scoreboard.md
Name: regfile_wb_scoreboard

Overview:
- Architectural register file at the far end of the writeback path. It consumes the WB-stage outputs (write enable, destination register, write data) and serves the two ID-stage read ports.
- Adds write-to-read bypass in the same cycle.
- Adds a per-register pending-write scoreboard. ID sets an entry at issue; WB or a kill clears it. The block raises a stall while a source operand still has an older write in flight.
- Sits between the WB stage (write side) and the ID stage / hazard logic (read side).

Parameters:
- DATA_W, 32, register width.
- NREGS, 32, number of architectural registers (address width = log2 NREGS = 5).
- CNT_W, 2, width of each in-flight counter; maximum in-flight writes per register = 2^CNT_W - 1 = 3.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- wb_reg_write  input  1  writeback enable from the WB stage.
- wb_write_reg  input  5  writeback destination register.
- wb_write_data  input  32  writeback data.
- rs_addr  input  5  ID read port A address.
- rt_addr  input  5  ID read port B address.
- rs_used  input  1  ID instruction actually reads rs.
- rt_used  input  1  ID instruction actually reads rt.
- rs_data  output  32  read port A data.
- rt_data  output  32  read port B data.
- id_issue  input  1  ID instruction advances to EX this cycle.
- id_dest_valid  input  1  issuing instruction writes a register.
- id_dest_reg  input  5  issuing instruction's destination register.
- kill_valid  input  1  an in-flight writer was squashed and will never reach WB.
- kill_reg  input  5  destination register of the squashed writer.
- stall  output  1  ID must hold; suppresses its own id_issue.
- issue_ready  output  1  destination counter has room; low means stall.

Behaviour:
- Reset:
  - On rst high at a clk edge, all registers clear to 0 and all counters clear to 0.
  - rst overrides any write, issue or kill in that same cycle.
  - Outputs while rst is asserted: stall=0, issue_ready=1.
  - Outputs are combinational from state and inputs, so after reset rs_data and rt_data read 0.
- Register 0:
  - Always reads 0.
  - Writes to it are ignored.
  - Its counter stays 0.
  - Issue or kill targeting r0 is ignored.
  - Never contributes to stall.
- Write:
  - When wb_reg_write=1 and wb_write_reg!=0, regs[wb_write_reg] <= wb_write_data at the clk edge.
- Read (combinational, zero latency):
  - rs_data = wb_write_data if wb_reg_write=1, wb_write_reg==rs_addr and rs_addr!=0.
  - Otherwise rs_data = regs[rs_addr].
  - rt_data follows the same rule with rt_addr.
- Counter update per register r != 0. Each counter gets a net delta:
  - +1 if id_issue & id_dest_valid & id_dest_reg==r.
  - -1 if wb_reg_write & wb_write_reg==r.
  - -1 if kill_valid & kill_reg==r.
  - Simultaneous events on the same register sum. Example: issue + WB gives net 0.
  - A decrement at count 0 is a protocol error. The counter stays at 0 (no underflow wrap) and a simulation-only assertion fires.
  - An increment at max is prevented by issue_ready. If the environment issues anyway, the counter saturates at max and an assertion fires.
- Busy:
  - busy(a) = (a!=0) & (cnt[a] - (wb_reg_write & wb_write_reg==a)) > 0.
  - The WB write in the current cycle retires one pending write. The bypass then supplies the data.
- issue_ready = !(id_dest_valid & id_dest_reg!=0 & cnt[id_dest_reg]==max & !(wb_reg_write & wb_write_reg==id_dest_reg)).
- stall = (rs_used & busy(rs_addr)) | (rt_used & busy(rt_addr)) | !issue_ready.
- Same-cycle issue and busy check:
  - The busy check uses state before this cycle's issue.
  - An instruction never stalls on its own destination.
- Kill and WB on the same register in one cycle: both decrement.

Decomposition:
- Shared pipeline package holds:
  - REG_ADDR_W = 5.
  - DATA_W = 32.
  - ZERO_REG = 5'd0.
  - A typedef for the writeback bundle {reg_write, write_reg, write_data}, shared with the WB stage.
- One sub-module, sb_counter: a single saturating up/down counter with inc, dec_a, dec_b, count, nonzero outputs. It is instantiated NREGS-1 times through generate.

Test Plan:
1. Reset and r0.
   - Stimulus: assert rst for 2 cycles; read all 32 regs; then WB writes 0xDEADBEEF to r0.
   - Required: all reads 0; stall=0; r0 still reads 0.
2. Write then read with bypass.
   - Stimulus: WB writes r5=0x12345678 with rs_addr=5 in the same cycle.
   - Required: rs_data=0x12345678 in that cycle and in the next cycle.
3. Load-use stall.
   - Stimulus: issue dest r7; next cycle rs_addr=7, rs_used=1.
   - Required: stall=1 until the cycle WB writes r7=0xA5A5A5A5. In that cycle stall=0 and rs_data=0xA5A5A5A5.
4. Counter saturation.
   - Stimulus: issue dest r3 three times with no WB; fourth issue to r3.
   - Required: issue_ready=0 and stall=1. After one WB to r3, issue_ready=1.
5. Simultaneous events.
   - Stimulus: count[9]=1; issue dest r9 and WB r9 in the same cycle.
   - Required: count stays 1; rt_used on r9 next cycle gives stall=1.
6. Kill and reset mid-flight.
   - Stimulus: issue r4 twice; kill r4 once.
   - Required: count=1.
   - Stimulus: assert rst with WB r4 pending.
   - Required: count=0, regs[4]=0, stall=0.
